// File: rtl/sr_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sr_cmd_pkg
// Shared types and helpers for the SR flip-flop command generator.
//   state_t   : pulse FSM states (IDLE, PULSE, GAP)
//   cmd_t     : arbitrated command (NONE, SET, CLR)
//   cnt_width : counter width able to hold the largest of three cycle counts
// -----------------------------------------------------------------------------
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        SET  = 2'd1,
        CLR  = 2'd2
    } cmd_t;

    // Width of a counter that must represent values up to max(a, b, c).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    // Counter width for the default parameter set (4, 2, 2).
    localparam int DEFAULT_CNT_W = cnt_width(4, 2, 2);

endpackage

// File: rtl/sr_debounce.sv
// -----------------------------------------------------------------------------
// sr_debounce
// Two-flop synchronizer, debounce counter and rising-edge detector for one
// raw asynchronous request line.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   raw_i  in  raw asynchronous request (active high)
//   req_o  out one-cycle registered pulse per debounced rising edge
// -----------------------------------------------------------------------------
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic req_o
);

    localparam int                DB_W    = cnt_width(DEBOUNCE_CYCLES, 1, 0);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;
    logic            level_q;
    logic            level_d;
    logic            level_prev_q;
    logic            req_q;

    // The level flips only after DEBOUNCE_CYCLES consecutive differing
    // samples; any matching sample restarts the count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others (the synchronizer chain
    // depends on this).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            sync1_q      <= raw_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            req_q        <= level_q & ~level_prev_q;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// -----------------------------------------------------------------------------
// sr_cmd_gen
// Turns debounced set/clear requests into fixed-length S or R pulses for a
// downstream SR flip-flop, with a minimum gap between pulses and a one-entry
// pending command. S and R can never be high together.
//   clk       in  clock
//   reset_n   in  asynchronous active-low reset
//   set_in    in  raw asynchronous set request
//   clr_in    in  raw asynchronous clear request
//   S         out registered set pulse (PULSE_LEN cycles)
//   R         out registered reset pulse (PULSE_LEN cycles)
//   busy      out registered, high during PULSE and GAP
//   conflict  out one-cycle flag: simultaneous set/clear requests discarded
//   dropped   out one-cycle flag: pending command overwritten
// -----------------------------------------------------------------------------
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 2,
    parameter int GAP_LEN         = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic set_in,
    input  logic clr_in,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic dropped
);

    localparam int                CNT_W      = cnt_width(DEBOUNCE_CYCLES, PULSE_LEN, GAP_LEN);
    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    logic set_req;
    logic clr_req;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk   (clk),
        .rst_n (reset_n),
        .raw_i (set_in),
        .req_o (set_req)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk   (clk),
        .rst_n (reset_n),
        .raw_i (clr_in),
        .req_o (clr_req)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cmd_t             cur_q, cur_d;
    cmd_t             pend_q, pend_d;
    cmd_t             cmd;
    logic             take_pend;
    logic             s_q, r_q, busy_q, conflict_q, dropped_q;
    logic             dropped_d;

    // Simultaneous requests cancel each other.
    always_comb begin
        cmd = NONE;
        if (set_req && !clr_req) cmd = SET;
        else if (clr_req && !set_req) cmd = CLR;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        pend_d    = pend_q;
        take_pend = 1'b0;
        dropped_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd != NONE) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LAST;
                    cur_d   = cmd;
                end
            end
            PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (GAP_LEN > 0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LAST;
                end else if (pend_q != NONE) begin
                    state_d   = PULSE;
                    cnt_d     = PULSE_LAST;
                    cur_d     = pend_q;
                    take_pend = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (pend_q != NONE) begin
                    state_d   = PULSE;
                    cnt_d     = PULSE_LAST;
                    cur_d     = pend_q;
                    take_pend = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A command arriving while busy is queued; one arriving on the same
        // cycle the queue drains becomes the new entry without a drop.
        if (take_pend) pend_d = NONE;
        if ((state_q != IDLE) && (cmd != NONE)) begin
            pend_d    = cmd;
            dropped_d = (pend_q != NONE) && !take_pend;
        end
    end

    // Outputs are decoded from next state so they are registered yet line up
    // with the state they describe. cur_d is a single command, so S and R are
    // mutually exclusive by construction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_q      <= NONE;
            pend_q     <= NONE;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            s_q        <= (state_d == PULSE) && (cur_d == SET);
            r_q        <= (state_d == PULSE) && (cur_d == CLR);
            busy_q     <= (state_d != IDLE);
            conflict_q <= set_req & clr_req;
            dropped_q  <= dropped_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign dropped  = dropped_q;

endmodule
